// File: rtl/checkbits_seq_monitor.sv
// Synchronizes and de-glitches the firmware checkbits bus and tracks an ordered list of
// progress codes, reporting per-step hits, a sticky pass/fail verdict and a timeout.
module checkbits_seq_monitor #(
  parameter int unsigned N_STEPS        = 3,
  parameter logic [15:0] STEP0          = 16'hAB40,
  parameter logic [15:0] STEP1          = 16'h2233,
  parameter logic [15:0] STEP2          = 16'hAB51,
  parameter logic [15:0] STEP3          = 16'h0000,
  parameter int unsigned STABLE_CYCLES  = 4,
  parameter int unsigned TIMEOUT_CYCLES = 2500000,
  parameter int unsigned TO_W           = 22
) (
  input  logic        clock,
  input  logic        resetb,
  input  logic        enable,
  input  logic [15:0] checkbits_in,
  output logic        step_hit,
  output logic [1:0]  step_idx,
  output logic [15:0] last_value,
  output logic        pass,
  output logic        fail,
  output logic        busy
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StWait = 2'd1;
  localparam logic [1:0] StPass = 2'd2;
  localparam logic [1:0] StFail = 2'd3;

  // Qualify on the cycle the counter steps onto STABLE_CYCLES-1; a value needs
  // STABLE_CYCLES identical pad samples. STABLE_CYCLES=1 still needs one repeat.
  localparam logic [7:0] QualAt    = (STABLE_CYCLES > 1) ? 8'(STABLE_CYCLES - 1) : 8'd1;
  localparam logic [7:0] StabMax   = 8'(STABLE_CYCLES);
  localparam logic [1:0] LastIdx   = 2'(N_STEPS - 1);
  localparam logic [TO_W-1:0] ToLast = TO_W'(TIMEOUT_CYCLES - 1);

  logic [15:0]     meta_q, sync_q, prev_q, last_q;
  logic [7:0]      stab_cnt_q, stab_cnt_d;
  logic            same, qual;

  logic [1:0]      state_q, state_d;
  logic [1:0]      step_idx_q, step_idx_d;
  logic            pass_q, pass_d, fail_q, fail_d, hit_q, hit_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic [15:0]     step_code;
  logic            match, timeout, final_step;

  always_comb begin
    same = (sync_q == prev_q);
    qual = same && (stab_cnt_q == QualAt - 8'd1);
    if (!same) begin
      stab_cnt_d = 8'd0;
    end else if (stab_cnt_q < StabMax) begin
      stab_cnt_d = stab_cnt_q + 8'd1;
    end else begin
      stab_cnt_d = stab_cnt_q;
    end
  end

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      meta_q     <= '0;
      sync_q     <= '0;
      prev_q     <= '0;
      stab_cnt_q <= '0;
      last_q     <= '0;
    end else begin
      meta_q     <= checkbits_in;
      sync_q     <= meta_q;
      prev_q     <= sync_q;
      stab_cnt_q <= stab_cnt_d;
      if (qual) last_q <= sync_q;
    end
  end

  always_comb begin
    case (step_idx_q)
      2'd0:    step_code = STEP0;
      2'd1:    step_code = STEP1;
      2'd2:    step_code = STEP2;
      default: step_code = STEP3;
    endcase
  end

  // The qualifying value is compared as it is captured, so the hit lands with last_value.
  always_comb begin
    state_d    = state_q;
    step_idx_d = step_idx_q;
    pass_d     = pass_q;
    fail_d     = fail_q;
    to_cnt_d   = to_cnt_q;
    hit_d      = 1'b0;
    match      = qual && (sync_q == step_code);
    timeout    = (to_cnt_q == ToLast);
    final_step = (step_idx_q == LastIdx);
    case (state_q)
      StIdle: begin
        if (enable) begin
          state_d    = StWait;
          step_idx_d = 2'd0;
          pass_d     = 1'b0;
          fail_d     = 1'b0;
          to_cnt_d   = '0;
        end
      end
      StWait: begin
        if (!enable) begin
          state_d = StIdle;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
          if (match) begin
            hit_d = 1'b1;
            if (final_step) begin
              state_d = StPass;
              pass_d  = 1'b1;
            end else begin
              step_idx_d = step_idx_q + 2'd1;
            end
          end
          // A final match on the timeout cycle wins; a non-final one still fails.
          if (timeout && !(match && final_step)) begin
            state_d = StFail;
            fail_d  = 1'b1;
          end
        end
      end
      StPass, StFail: begin
        if (!enable) state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      state_q    <= StIdle;
      step_idx_q <= 2'd0;
      pass_q     <= 1'b0;
      fail_q     <= 1'b0;
      hit_q      <= 1'b0;
      to_cnt_q   <= '0;
    end else begin
      state_q    <= state_d;
      step_idx_q <= step_idx_d;
      pass_q     <= pass_d;
      fail_q     <= fail_d;
      hit_q      <= hit_d;
      to_cnt_q   <= to_cnt_d;
    end
  end

  assign step_hit   = hit_q;
  assign step_idx   = step_idx_q;
  assign last_value = last_q;
  assign pass       = pass_q;
  assign fail       = fail_q;
  assign busy       = (state_q == StWait);

endmodule

// File: tb/tb_checkbits_seq_monitor.sv
// Bench for checkbits_seq_monitor: three instances (nominal, short timeout, repeated code)
// share stimulus and are checked against a rule-level model of qualification and stepping.
module tb_checkbits_seq_monitor;

  localparam int Stab   = 4;
  localparam int Hist   = Stab + 4;
  localparam int NSteps = 3;
  localparam int Idle = 0, Run = 1, Done = 2;

  logic        clock = 1'b0;
  logic        resetb = 1'b0;
  logic        enable = 1'b0;
  logic [15:0] checkbits_in = 16'h0000;

  logic        hit_w  [3];
  logic [1:0]  idx_w  [3];
  logic [15:0] last_w [3];
  logic        pass_w [3];
  logic        fail_w [3];
  logic        busy_w [3];

  int passed = 0;
  int total  = 0;
  int cyc    = 0;

  logic [15:0] hist[$];
  logic [15:0] codes [3][4];
  int          tmo [3];
  int          m_mode [3], m_idx [3], m_elapsed [3];
  bit          m_hit [3], m_pass [3], m_fail [3];
  logic [15:0] m_last [3];
  int          obs_hits [3], pass_rise [3], fail_rise [3];
  bit          prev_pass [3], prev_fail [3];

  always #5 clock = ~clock;

  checkbits_seq_monitor #(.TIMEOUT_CYCLES(400), .TO_W(9)) dut_a (
    .clock(clock), .resetb(resetb), .enable(enable), .checkbits_in(checkbits_in),
    .step_hit(hit_w[0]), .step_idx(idx_w[0]), .last_value(last_w[0]),
    .pass(pass_w[0]), .fail(fail_w[0]), .busy(busy_w[0])
  );

  checkbits_seq_monitor #(.TIMEOUT_CYCLES(100), .TO_W(7)) dut_b (
    .clock(clock), .resetb(resetb), .enable(enable), .checkbits_in(checkbits_in),
    .step_hit(hit_w[1]), .step_idx(idx_w[1]), .last_value(last_w[1]),
    .pass(pass_w[1]), .fail(fail_w[1]), .busy(busy_w[1])
  );

  checkbits_seq_monitor #(.STEP1(16'hAB40), .TIMEOUT_CYCLES(400), .TO_W(9)) dut_c (
    .clock(clock), .resetb(resetb), .enable(enable), .checkbits_in(checkbits_in),
    .step_hit(hit_w[2]), .step_idx(idx_w[2]), .last_value(last_w[2]),
    .pass(pass_w[2]), .fail(fail_w[2]), .busy(busy_w[2])
  );

  // One clock edge: update the model from the inputs sampled at the edge, then observe.
  task automatic tick();
    logic [15:0] cand;
    int n, rl;
    bit qual, en;
    @(posedge clock);
    cyc++;
    en = enable;
    hist.push_back(checkbits_in);
    if (hist.size() > Hist) void'(hist.pop_front());
    n = hist.size();
    cand = hist[n-3];
    rl = 0;
    for (int j = n - 3; j >= 0; j--) begin
      if (hist[j] != cand) break;
      rl++;
    end
    // A run of exactly Stab samples, seen two edges late, qualifies once.
    qual = (rl == Stab);
    for (int i = 0; i < 3; i++) begin
      m_hit[i] = 1'b0;
      if (m_mode[i] == Idle) begin
        if (en) begin
          m_mode[i] = Run; m_idx[i] = 0; m_pass[i] = 0; m_fail[i] = 0; m_elapsed[i] = 0;
        end
      end else if (!en) begin
        m_mode[i] = Idle;
      end else if (m_mode[i] == Run) begin
        if (qual && cand == codes[i][m_idx[i]]) begin
          m_hit[i] = 1'b1;
          if (m_idx[i] == NSteps - 1) begin
            m_pass[i] = 1'b1; m_mode[i] = Done;
          end else begin
            m_idx[i]++;
          end
        end
        if (m_mode[i] == Run && m_elapsed[i] == tmo[i] - 1) begin
          m_fail[i] = 1'b1; m_mode[i] = Done;
        end
        m_elapsed[i]++;
      end
      if (qual) m_last[i] = cand;
    end
    #1;
    for (int i = 0; i < 3; i++) begin
      if (hit_w[i]) obs_hits[i]++;
      if (pass_w[i] && !prev_pass[i]) pass_rise[i] = cyc;
      if (fail_w[i] && !prev_fail[i]) fail_rise[i] = cyc;
      prev_pass[i] = pass_w[i];
      prev_fail[i] = fail_w[i];
    end
  endtask

  task automatic hold(input logic [15:0] v, input int cycles);
    checkbits_in = v;
    repeat (cycles) tick();
  endtask

  task automatic do_reset();
    enable = 1'b0;
    checkbits_in = 16'h0000;
    resetb = 1'b0;
    repeat (2) @(posedge clock);
    #1 resetb = 1'b1;
    hist.delete();
    repeat (Hist) hist.push_back(16'h0000);
    for (int i = 0; i < 3; i++) begin
      m_mode[i] = Idle; m_idx[i] = 0; m_elapsed[i] = 0; m_hit[i] = 0;
      m_pass[i] = 0; m_fail[i] = 0; m_last[i] = 16'h0000;
      obs_hits[i] = 0; pass_rise[i] = -1; fail_rise[i] = -1;
      prev_pass[i] = 0; prev_fail[i] = 0;
    end
    repeat (10) tick();
  endtask

  task automatic test_reset();
    logic [21:0] got;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      got = {hit_w[i], idx_w[i], last_w[i], pass_w[i], fail_w[i], busy_w[i]};
      total++;
      if (got !== 22'h0) $display("FAIL reset_values[%0d]: got %h expected 0", i, got);
      else passed++;
    end
    enable = 1'b1;
    tick();
    hold(16'hAB40, 10);
    #2 resetb = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      got = {hit_w[i], idx_w[i], last_w[i], pass_w[i], fail_w[i], busy_w[i]};
      total++;
      if (got !== 22'h0) $display("FAIL async_reset[%0d]: got %h expected 0", i, got);
      else passed++;
    end
  endtask

  task automatic test_nominal();
    int k;
    do_reset();
    enable = 1'b1;
    tick();
    total++;
    if (busy_w[0] !== 1'b1) $display("FAIL nominal_busy: got %b expected 1", busy_w[0]);
    else passed++;
    hold(16'hAB40, 20);
    total++;
    if (idx_w[0] !== 2'd1) $display("FAIL nominal_idx_after_ab40: got %0d expected 1", idx_w[0]);
    else passed++;
    hold(16'h1234, 20);
    total++;
    if (idx_w[0] !== 2'd1) $display("FAIL nominal_idx_after_1234: got %0d expected 1", idx_w[0]);
    else passed++;
    hold(16'h2233, 20);
    total++;
    if (idx_w[0] !== 2'd2) $display("FAIL nominal_idx_after_2233: got %0d expected 2", idx_w[0]);
    else passed++;
    k = cyc;
    hold(16'hAB51, 20);
    total++;
    if ({pass_w[0], fail_w[0], busy_w[0]} !== 3'b100)
      $display("FAIL nominal_verdict: got pass/fail/busy %b expected 100",
               {pass_w[0], fail_w[0], busy_w[0]});
    else passed++;
    total++;
    if (last_w[0] !== 16'hAB51) $display("FAIL nominal_last: got %h expected ab51", last_w[0]);
    else passed++;
    total++;
    if (obs_hits[0] != 3) $display("FAIL nominal_hits: got %0d expected 3", obs_hits[0]);
    else passed++;
    total++;
    if (pass_rise[0] != k + 2 + Stab)
      $display("FAIL nominal_pass_latency: got edge %0d expected %0d", pass_rise[0], k + 2 + Stab);
    else passed++;
    enable = 1'b0;
    tick();
    total++;
    if ({pass_w[0], busy_w[0]} !== 2'b10)
      $display("FAIL nominal_pass_held: got pass/busy %b expected 10", {pass_w[0], busy_w[0]});
    else passed++;
  endtask

  task automatic test_glitch();
    do_reset();
    enable = 1'b1;
    tick();
    hold(16'hAB40, 10);
    hold(16'h2233, 3);
    hold(16'hAB51, 10);
    total++;
    if (idx_w[0] !== 2'd1 || obs_hits[0] != 1)
      $display("FAIL glitch_rejected: got idx %0d hits %0d expected idx 1 hits 1",
               idx_w[0], obs_hits[0]);
    else passed++;
    hold(16'h2233, 4);
    hold(16'hAB51, 2);
    total++;
    if (idx_w[0] !== 2'd2 || hit_w[0] !== 1'b1)
      $display("FAIL glitch_four_cycles: got idx %0d hit %b expected idx 2 hit 1",
               idx_w[0], hit_w[0]);
    else passed++;
    hold(16'hAB51, 10);
    total++;
    if (pass_w[0] !== 1'b1 || obs_hits[0] != 3)
      $display("FAIL glitch_pass: got pass %b hits %0d expected pass 1 hits 3",
               pass_w[0], obs_hits[0]);
    else passed++;
  endtask

  task automatic test_timeout();
    int e;
    do_reset();
    enable = 1'b1;
    tick();
    e = cyc;
    hold(16'hAB40, 10);
    hold(16'h0000, 100);
    total++;
    if (fail_rise[1] != e + 100)
      $display("FAIL timeout_edge: got edge %0d expected %0d", fail_rise[1], e + 100);
    else passed++;
    total++;
    if ({idx_w[1], pass_w[1], fail_w[1], busy_w[1]} !== 5'b01010)
      $display("FAIL timeout_state: got idx/pass/fail/busy %b expected 01010",
               {idx_w[1], pass_w[1], fail_w[1], busy_w[1]});
    else passed++;
  endtask

  task automatic test_repeat_code();
    do_reset();
    enable = 1'b1;
    tick();
    hold(16'hAB40, 30);
    total++;
    if (obs_hits[2] != 1 || idx_w[2] !== 2'd1)
      $display("FAIL repeat_held: got hits %0d idx %0d expected hits 1 idx 1",
               obs_hits[2], idx_w[2]);
    else passed++;
    hold(16'h0000, 10);
    hold(16'hAB40, 10);
    total++;
    if (obs_hits[2] != 2 || idx_w[2] !== 2'd2)
      $display("FAIL repeat_return: got hits %0d idx %0d expected hits 2 idx 2",
               obs_hits[2], idx_w[2]);
    else passed++;
  endtask

  task automatic test_abort_reset();
    logic [21:0] got;
    do_reset();
    enable = 1'b1;
    tick();
    hold(16'hAB40, 10);
    total++;
    if (obs_hits[0] != 1) $display("FAIL abort_first_hit: got %0d expected 1", obs_hits[0]);
    else passed++;
    enable = 1'b0;
    tick();
    total++;
    if (busy_w[0] !== 1'b0) $display("FAIL abort_busy: got %b expected 0", busy_w[0]);
    else passed++;
    enable = 1'b1;
    tick();
    total++;
    if ({idx_w[0], busy_w[0]} !== 3'b001)
      $display("FAIL abort_restart: got idx/busy %b expected 001", {idx_w[0], busy_w[0]});
    else passed++;
    hold(16'h2233, 5);
    #2 resetb = 1'b0;
    #1;
    got = {hit_w[0], idx_w[0], last_w[0], pass_w[0], fail_w[0], busy_w[0]};
    total++;
    if (got !== 22'h0) $display("FAIL abort_async_reset: got %h expected 0", got);
    else passed++;
  endtask

  task automatic test_simultaneous();
    int e;
    do_reset();
    enable = 1'b1;
    tick();
    e = cyc;
    hold(16'hAB40, 10);
    hold(16'h2233, 10);
    hold(16'h0000, e + 94 - cyc);
    hold(16'hAB51, 11);
    total++;
    if ({pass_w[1], fail_w[1]} !== 2'b10)
      $display("FAIL simultaneous_verdict: got pass/fail %b expected 10", {pass_w[1], fail_w[1]});
    else passed++;
    total++;
    if (pass_rise[1] != e + 100)
      $display("FAIL simultaneous_edge: got edge %0d expected %0d", pass_rise[1], e + 100);
    else passed++;
  endtask

  task automatic test_random();
    logic [15:0] vals [5];
    logic [21:0] got, exp;
    vals[0] = 16'hAB40; vals[1] = 16'h2233; vals[2] = 16'hAB51;
    vals[3] = 16'h1234; vals[4] = 16'h0000;
    do_reset();
    enable = 1'b1;
    for (int s = 0; s < 120; s++) begin
      checkbits_in = vals[$urandom_range(0, 4)];
      if ($urandom_range(0, 9) == 0) enable = ~enable;
      repeat ($urandom_range(1, 8)) begin
        tick();
        for (int i = 0; i < 3; i++) begin
          got = {hit_w[i], idx_w[i], last_w[i], pass_w[i], fail_w[i], busy_w[i]};
          exp = {m_hit[i], 2'(m_idx[i]), m_last[i], m_pass[i], m_fail[i], m_mode[i] == Run};
          total++;
          if (got !== exp)
            $display("FAIL random[%0d] edge %0d: got %h expected %h", i, cyc, got, exp);
          else passed++;
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      codes[i][0] = 16'hAB40; codes[i][1] = 16'h2233;
      codes[i][2] = 16'hAB51; codes[i][3] = 16'h0000;
    end
    codes[2][1] = 16'hAB40;
    tmo[0] = 400; tmo[1] = 100; tmo[2] = 400;
    test_reset();
    test_nominal();
    test_glitch();
    test_timeout();
    test_repeat_code();
    test_abort_reset();
    test_simultaneous();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
